// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : voice_allocator
// Purpose  : Polyphonic note-to-voice allocator with oldest-voice stealing,
//            plus a serial saturating mixer of the per-voice samples.
// Revision : 1.0 - initial release
// ============================================================================
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int DATA_BITS  = 16,
    parameter int AGE_BITS   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            event_valid,
    output logic                            event_ready,
    input  logic                            event_on,
    input  logic [7:0]                      event_note,
    output logic [NUM_VOICES*8-1:0]         voice_note,
    output logic [NUM_VOICES-1:0]           voice_gate,
    input  logic                            sample_tick,
    input  logic [NUM_VOICES*DATA_BITS-1:0] voice_din,
    output logic [DATA_BITS-1:0]            mix_dout,
    output logic                            mix_valid
);

    localparam int c_IDX_W = $clog2(NUM_VOICES);
    localparam int c_ACC_W = DATA_BITS + c_IDX_W;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(NUM_VOICES - 1);
    localparam logic signed [c_ACC_W-1:0] c_MAX = {{(c_IDX_W+1){1'b0}}, {(DATA_BITS-1){1'b1}}};
    localparam logic signed [c_ACC_W-1:0] c_MIN = ~c_MAX;

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_SCAN      = 3'd1;
    localparam logic [2:0] c_ST_APPLY     = 3'd2;
    localparam logic [2:0] c_ST_GATE_LOW  = 3'd3;
    localparam logic [2:0] c_ST_GATE_HIGH = 3'd4;

    logic [2:0]          r_state;
    logic                r_on;
    logic [7:0]          r_note_in;
    logic [c_IDX_W-1:0]  r_idx;
    logic                r_match_found, r_free_found, r_old_found;
    logic [c_IDX_W-1:0]  r_match_idx, r_free_idx, r_old_idx, r_target;
    logic [AGE_BITS-1:0] r_old_age;
    logic [NUM_VOICES-1:0] r_gate;
    logic [7:0]          r_note [NUM_VOICES];
    logic [AGE_BITS-1:0] r_age  [NUM_VOICES];

    logic                w_commit;
    logic [c_IDX_W-1:0]  w_commit_idx;

    assign event_ready = (r_state == c_ST_IDLE);
    assign voice_gate  = r_gate;

    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_note_out
        assign voice_note[gi*8 +: 8] = r_note[gi];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_on          <= 1'b0;
            r_note_in     <= '0;
            r_idx         <= '0;
            r_match_found <= 1'b0;
            r_free_found  <= 1'b0;
            r_old_found   <= 1'b0;
            r_match_idx   <= '0;
            r_free_idx    <= '0;
            r_old_idx     <= '0;
            r_old_age     <= '0;
            r_target      <= '0;
            r_gate        <= '0;
            for (int i = 0; i < NUM_VOICES; i++) r_note[i] <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (event_valid) begin
                        r_on          <= event_on;
                        r_note_in     <= event_note;
                        r_idx         <= '0;
                        r_match_found <= 1'b0;
                        r_free_found  <= 1'b0;
                        r_old_found   <= 1'b0;
                        r_state       <= c_ST_SCAN;
                    end
                end
                c_ST_SCAN: begin
                    if (r_gate[r_idx] && r_note[r_idx] == r_note_in && !r_match_found) begin
                        r_match_found <= 1'b1;
                        r_match_idx   <= r_idx;
                    end
                    if (!r_gate[r_idx] && !r_free_found) begin
                        r_free_found <= 1'b1;
                        r_free_idx   <= r_idx;
                    end
                    // Strict compare keeps the lowest index on equal ages
                    if (r_gate[r_idx] && (!r_old_found || r_age[r_idx] > r_old_age)) begin
                        r_old_found <= 1'b1;
                        r_old_idx   <= r_idx;
                        r_old_age   <= r_age[r_idx];
                    end
                    if (r_idx == c_LAST) r_state <= c_ST_APPLY;
                    else                 r_idx   <= r_idx + c_IDX_W'(1);
                end
                c_ST_APPLY: begin
                    r_state <= c_ST_IDLE;
                    if (r_on) begin
                        if (r_match_found) begin
                            r_gate[r_match_idx] <= 1'b0;
                            r_target            <= r_match_idx;
                            r_state             <= c_ST_GATE_LOW;
                        end else if (r_free_found) begin
                            r_note[r_free_idx] <= r_note_in;
                            r_gate[r_free_idx] <= 1'b1;
                        end else begin
                            r_gate[r_old_idx] <= 1'b0;
                            r_target          <= r_old_idx;
                            r_state           <= c_ST_GATE_LOW;
                        end
                    end else if (r_match_found) begin
                        r_gate[r_match_idx] <= 1'b0;
                    end
                end
                c_ST_GATE_LOW: r_state <= c_ST_GATE_HIGH;
                c_ST_GATE_HIGH: begin
                    r_note[r_target] <= r_note_in;
                    r_gate[r_target] <= 1'b1;
                    r_state          <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign w_commit = (r_state == c_ST_GATE_HIGH) ||
                      (r_state == c_ST_APPLY && r_on && !r_match_found && r_free_found);
    assign w_commit_idx = (r_state == c_ST_GATE_HIGH) ? r_target : r_free_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) r_age[i] <= '0;
        end else if (w_commit) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (c_IDX_W'(i) == w_commit_idx)
                    r_age[i] <= '0;
                else if (r_gate[i] && r_age[i] != '1)
                    r_age[i] <= r_age[i] + AGE_BITS'(1);
            end
        end
    end

    // Mixer: capture, N accumulate cycles, then a clamp/output cycle
    logic signed [DATA_BITS-1:0] r_stage [NUM_VOICES];
    logic signed [c_ACC_W-1:0]   r_acc;
    logic [c_IDX_W-1:0]          r_mix_idx;
    logic                        r_mix_busy, r_mix_fin, r_mix_valid;
    logic [DATA_BITS-1:0]        r_mix_dout;
    logic signed [c_ACC_W-1:0]   w_sext;
    logic [DATA_BITS-1:0]        w_clamped;

    assign w_sext    = {{c_IDX_W{r_stage[r_mix_idx][DATA_BITS-1]}}, r_stage[r_mix_idx]};
    assign mix_dout  = r_mix_dout;
    assign mix_valid = r_mix_valid;

    always_comb begin
        w_clamped = r_acc[DATA_BITS-1:0];
        if (r_acc > c_MAX)      w_clamped = c_MAX[DATA_BITS-1:0];
        else if (r_acc < c_MIN) w_clamped = c_MIN[DATA_BITS-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) r_stage[i] <= '0;
            r_acc       <= '0;
            r_mix_idx   <= '0;
            r_mix_busy  <= 1'b0;
            r_mix_fin   <= 1'b0;
            r_mix_valid <= 1'b0;
            r_mix_dout  <= '0;
        end else begin
            r_mix_valid <= 1'b0;
            if (r_mix_fin) begin
                r_mix_dout  <= w_clamped;
                r_mix_valid <= 1'b1;
                r_mix_busy  <= 1'b0;
                r_mix_fin   <= 1'b0;
            end else if (r_mix_busy) begin
                r_acc <= r_acc + w_sext;
                if (r_mix_idx == c_LAST) r_mix_fin <= 1'b1;
                else                     r_mix_idx <= r_mix_idx + c_IDX_W'(1);
            end
            // The output cycle counts as idle, so back-to-back ticks are accepted
            if (sample_tick && (!r_mix_busy || r_mix_fin)) begin
                for (int i = 0; i < NUM_VOICES; i++)
                    r_stage[i] <= voice_din[i*DATA_BITS +: DATA_BITS];
                r_acc      <= '0;
                r_mix_idx  <= '0;
                r_mix_busy <= 1'b1;
                r_mix_fin  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_voice_allocator
// Purpose  : Directed scoreboard bench for voice_allocator (N=4, 16-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_voice_allocator;

    logic        clk = 1'b0;
    logic        rst;
    logic        event_valid, event_on, sample_tick;
    logic        event_ready, mix_valid;
    logic [7:0]  event_note;
    logic [31:0] voice_note;
    logic [3:0]  voice_gate;
    logic [63:0] voice_din;
    logic [15:0] mix_dout;

    voice_allocator #(.NUM_VOICES(4), .DATA_BITS(16), .AGE_BITS(8)) dut (
        .clk(clk), .rst(rst),
        .event_valid(event_valid), .event_ready(event_ready),
        .event_on(event_on), .event_note(event_note),
        .voice_note(voice_note), .voice_gate(voice_gate),
        .sample_tick(sample_tick), .voice_din(voice_din),
        .mix_dout(mix_dout), .mix_valid(mix_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct { int at; logic [3:0] g; logic [31:0] n; } ev_t;
    typedef struct { int at; logic [15:0] v; } mx_t;
    ev_t evq[$];
    mx_t mxq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every change of the voice outputs and every mix pulse pops one expectation
    initial begin
        logic [35:0] prev;
        ev_t e;
        mx_t m;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = {voice_gate, voice_note};
            end else begin
                if ({voice_gate, voice_note} !== prev) begin
                    if (evq.size() == 0) begin
                        chk("unexpected_voice_change", {voice_gate, voice_note}, prev);
                    end else begin
                        e = evq.pop_front();
                        chk("voice_time", cyc, e.at);
                        chk("voice_gate", voice_gate, e.g);
                        chk("voice_note", voice_note, e.n);
                    end
                    prev = {voice_gate, voice_note};
                end
                if (mix_valid) begin
                    if (mxq.size() == 0) begin
                        chk("unexpected_mix_valid", mix_valid, 1'b0);
                    end else begin
                        m = mxq.pop_front();
                        chk("mix_time", cyc, m.at);
                        chk("mix_dout", mix_dout, m.v);
                    end
                end
            end
        end
    end

    // kind: 0 = no output change, 1 = single update at E5, 2 = gate drop at E5 then rise at E7
    task automatic send(input bit on, input logic [7:0] nt, input int kind,
                        input logic [3:0] gm, input logic [31:0] nm,
                        input logic [3:0] gf, input logic [31:0] nf);
        int  e0, w;
        ev_t e;
        w = 0;
        while (!event_ready && w < 50) begin @(negedge clk); w++; end
        if (!event_ready) begin
            chk("ready_timeout", event_ready, 1'b1);
            return;
        end
        event_valid = 1'b1; event_on = on; event_note = nt;
        @(posedge clk); #1;
        e0 = cyc;
        event_valid = 1'b0;
        if (kind == 1) begin
            e.at = e0 + 5; e.g = gf; e.n = nf; evq.push_back(e);
        end else if (kind == 2) begin
            e.at = e0 + 5; e.g = gm; e.n = nm; evq.push_back(e);
            e.at = e0 + 7; e.g = gf; e.n = nf; evq.push_back(e);
        end
        w = 0;
        do begin @(negedge clk); w++; end while (!event_ready && w < 50);
        chk("ready_latency", cyc - e0, (kind == 2) ? 7 : 5);
    endtask

    task automatic mix(input logic [63:0] din, input logic [15:0] exp);
        int  t0;
        mx_t m;
        voice_din = din; sample_tick = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        sample_tick = 1'b0;
        m.at = t0 + 5; m.v = exp; mxq.push_back(m);
        repeat (7) @(negedge clk);
        chk("mix_valid_low_after_pulse", mix_valid, 1'b0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        evq.delete(); mxq.delete();
        event_valid = 1'b0; sample_tick = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_gate", voice_gate, 4'h0);
        chk("rst_note", voice_note, 32'h0);
        chk("rst_ready", event_ready, 1'b1);
        chk("rst_mix_dout", mix_dout, 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; event_valid = 1'b0; event_on = 1'b0; event_note = '0;
        sample_tick = 1'b0; voice_din = '0;
        repeat (2) @(negedge clk);
        chk("reset_gate", voice_gate, 4'h0);
        chk("reset_note", voice_note, 32'h0);
        chk("reset_ready", event_ready, 1'b1);
        chk("reset_mix_dout", mix_dout, 16'h0);
        chk("reset_mix_valid", mix_valid, 1'b0);
        #2 rst = 1'b0;
        @(negedge clk);

        // Fill all four slots, then steal twice (oldest slot 0, then oldest slot 1)
        send(1, 8'd60, 1, 4'h0, 32'h0,        4'b0001, 32'h0000003C);
        send(1, 8'd62, 1, 4'h0, 32'h0,        4'b0011, 32'h00003E3C);
        send(1, 8'd64, 1, 4'h0, 32'h0,        4'b0111, 32'h00403E3C);
        send(1, 8'd65, 1, 4'h0, 32'h0,        4'b1111, 32'h41403E3C);
        send(1, 8'd67, 2, 4'b1110, 32'h41403E3C, 4'b1111, 32'h41403E43);
        send(1, 8'd69, 2, 4'b1101, 32'h41403E43, 4'b1111, 32'h41404543);
        // Release, drop unknown, reallocate freed slot, retrigger held note
        send(0, 8'd64, 1, 4'h0, 32'h0,        4'b1011, 32'h41404543);
        send(0, 8'd70, 0, 4'h0, 32'h0,        4'h0,    32'h0);
        send(1, 8'd64, 1, 4'h0, 32'h0,        4'b1111, 32'h41404543);
        send(1, 8'd65, 2, 4'b0111, 32'h41404543, 4'b1111, 32'h41404543);

        do_reset();
        send(1, 8'd60, 1, 4'h0, 32'h0,        4'b0001, 32'h0000003C);
        send(1, 8'd60, 2, 4'b0000, 32'h0000003C, 4'b0001, 32'h0000003C);
        send(1, 8'd62, 1, 4'h0, 32'h0,        4'b0011, 32'h00003E3C);
        send(0, 8'd62, 1, 4'h0, 32'h0,        4'b0001, 32'h00003E3C);
        send(0, 8'd70, 0, 4'h0, 32'h0,        4'h0,    32'h0);

        mix({16'h7530, 16'h7530, 16'h7530, 16'h7530}, 16'h7FFF);
        mix({16'hB1E0, 16'hB1E0, 16'hB1E0, 16'hB1E0}, 16'h8000);
        mix({16'h0000, 16'h0007, 16'hFFCE, 16'h0064}, 16'h0039);

        fork
            send(1, 8'd66, 1, 4'h0, 32'h0, 4'b0011, 32'h0000423C);
            mix({16'h0004, 16'h0003, 16'h0002, 16'h0001}, 16'h000A);
        join

        // Reset during SCAN
        event_valid = 1'b1; event_on = 1'b1; event_note = 8'd50;
        @(posedge clk); #1;
        event_valid = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset during accumulation; the monitor flags any later mix pulse
        voice_din = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        @(negedge clk); @(negedge clk);
        do_reset();
        repeat (10) @(negedge clk);
        chk("post_reset_ready", event_ready, 1'b1);
        chk("post_reset_mix_valid", mix_valid, 1'b0);

        chk("event_queue_empty", evq.size(), 0);
        chk("mix_queue_empty", mxq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
